// File: rtl/pcle_ctr_pkg.sv
// Shared constants and types for the pcle_ctr counter slice.
package pcle_pkg;

  localparam int unsigned PCLE_WIDTH = 8;

  typedef enum logic {
    PCLE_DOWN = 1'b0,
    PCLE_UP   = 1'b1
  } pcle_dir_t;

endpackage

// File: rtl/pcle_ctr_term.sv
// Terminal-value detector: all-ones when counting up, all-zeros when counting down.
module pcle_ctr_term
  import pcle_pkg::*;
#(
  parameter int unsigned WIDTH = PCLE_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  pcle_dir_t        up,
  output logic             term
);

  assign term = (up == PCLE_UP) ? (&q) : (&(~q));

endmodule

// File: rtl/pcle_ctr.sv
// Loadable up/down counter with cascade carry, terminal count and sticky wrap flag.
// Build option: define PCLE_CTR_SAT_EN to saturate at the terminal value instead of wrapping.
module pcle_ctr
  import pcle_pkg::*;
#(
  parameter int unsigned      WIDTH   = PCLE_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             inh,
  input  logic             ci,
  input  logic             up,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             run;
  logic             cnt;
  logic             term;
  logic [WIDTH-1:0] q_nxt;
  logic             ovf_nxt;

  pcle_ctr_term #(
    .WIDTH (WIDTH)
  ) u_term (
    .q    (q),
    .up   (pcle_dir_t'(up)),
    .term (term)
  );

  assign run = en & ~inh & ci;
  assign cnt = run & ~ld;
  // Carry-out ignores ld so a downstream stage sees the carry during a load.
  assign tc  = run & term & rst_n;

  always_comb begin
    q_nxt = q;
    if (ld) begin
      q_nxt = d;
    end else if (cnt) begin
`ifdef PCLE_CTR_SAT_EN
      if (!term) begin
        q_nxt = up ? (q + ONE) : (q - ONE);
      end
`else
      q_nxt = up ? (q + ONE) : (q - ONE);
`endif
    end
  end

  always_comb begin
    ovf_nxt = ovf;
    if (ld || clr_ovf) begin
      ovf_nxt = 1'b0;
    end else if (cnt && term) begin
      ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= RST_VAL;
      ovf <= 1'b0;
    end else begin
      q   <= q_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule
